main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single rising-edge clock for the block.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset; the block is in reset while reset=0.
REQ-003 The block SHALL have the port Op, input, 2 bits: instruction class (00 data-processing, 01 memory, 10 branch, 11 undefined).
REQ-004 The block SHALL have the port Funct, input, 6 bits: instruction Funct field; bit 5 = I (immediate), bit 0 = L/S (load when 1).
REQ-005 The block SHALL have the port IRWrite, output, 1 bit: instruction register load enable.
REQ-006 The block SHALL have the port AdrSrc, output, 1 bit: memory address select (0 PC, 1 ALUOut).
REQ-007 The block SHALL have the port ALUSrcA, output, 2 bits: ALU operand A select (00 register A, 01 PC, 10 ALUOut).
REQ-008 The block SHALL have the port ALUSrcB, output, 2 bits: ALU operand B select (00 register WriteData, 01 ExtImm, 10 constant 4).
REQ-009 The block SHALL have the port ResultSrc, output, 2 bits: result mux select (00 ALUOut, 01 Data, 10 ALUResult).
REQ-010 The block SHALL have the port ALUOp, output, 1 bit: 1 = ALU decoder uses Funct; 0 = force ADD.
REQ-011 The block SHALL have the port NextPC, output, 1 bit: unconditional PC write request to the conditional logic.
REQ-012 The block SHALL have the port RegW, output, 1 bit: register write request (gated downstream by the condition).
REQ-013 The block SHALL have the port MemW, output, 1 bit: memory write request (gated downstream by the condition).
REQ-014 The block SHALL have the port Branch, output, 1 bit: branch PC-write request (gated downstream by the condition).
REQ-015 The block SHALL have the port InstrDone, output, 1 bit: one-cycle pulse asserted in the last state of each instruction.

Function
REQ-016 The block SHALL be a Moore FSM with the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH and UNKNOWN.
REQ-017 The FSM SHALL make the transitions FETCH->DECODE, MEMRD->MEMWB, and MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN->FETCH, each unconditionally.
REQ-018 From DECODE, the FSM SHALL go to MEMADR when Op=01, EXECUTER when Op=00 and Funct[5]=0, EXECUTEI when Op=00 and Funct[5]=1, BRANCH when Op=10, and UNKNOWN when Op=11.
REQ-019 From MEMADR, the FSM SHALL go to MEMRD when Funct[0]=1 and to MEMWR when Funct[0]=0.
REQ-020 In FETCH the block SHALL drive IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10 and ALUOp=0.
REQ-021 In DECODE the block SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=10 and ALUOp=0.
REQ-022 In MEMADR the block SHALL drive ALUSrcA=00, ALUSrcB=01 and ALUOp=0.
REQ-023 In MEMRD the block SHALL drive AdrSrc=1 and ResultSrc=00.
REQ-024 In MEMWB the block SHALL drive ResultSrc=01, RegW=1 and InstrDone=1.
REQ-025 In MEMWR the block SHALL drive AdrSrc=1, ResultSrc=00, MemW=1 and InstrDone=1.
REQ-026 In EXECUTER the block SHALL drive ALUSrcA=00, ALUSrcB=00 and ALUOp=1.
REQ-027 In EXECUTEI the block SHALL drive ALUSrcA=00, ALUSrcB=01 and ALUOp=1.
REQ-028 In ALUWB the block SHALL drive ResultSrc=00, RegW=1 and InstrDone=1.
REQ-029 In BRANCH the block SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1 and InstrDone=1.
REQ-030 In UNKNOWN the block SHALL drive all outputs to 0 except InstrDone=1, so no architectural write occurs.
REQ-031 Every output not listed for a state SHALL be 0; the block SHALL leave no output as don't-care.
REQ-032 Instruction latencies from FETCH to FETCH SHALL be 5 cycles for LDR, 4 for STR, 4 for data-processing, 3 for branch and 3 for undefined.
REQ-033 Op and Funct SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.
REQ-034 An illegal state encoding SHALL transition to FETCH on the next clock.

Reset
REQ-035 Asserting reset (reset=0) SHALL immediately force the state to FETCH, at any point including mid-instruction.
REQ-036 While reset=0, every output SHALL be driven to 0, overriding the FETCH decode.
REQ-037 On the first rising clk edge with reset=1, the block SHALL be in FETCH with the FETCH outputs of REQ-020.

Structure
REQ-038 The state encoding (4-bit enum) and the ALUSrcA, ALUSrcB and ResultSrc select constants SHALL live in the shared package main_fsm_pkg, which the datapath also uses.
REQ-039 The state-to-output table SHALL be implemented as the combinational sub-module main_fsm_outdec; the state register and next-state logic SHALL be implemented in main_fsm.

Verification
REQ-040 The bench SHALL release reset with Op=01, Funct=000001 and check IRWrite=1 and NextPC=1 in cycle 1, then DECODE, MEMADR, MEMRD, then MEMWB with RegW=1, ResultSrc=01 and InstrDone=1, then FETCH.
REQ-041 The bench SHALL apply Op=01, Funct=000000 and check MEMWR in cycle 4 with MemW=1, AdrSrc=1 and RegW=0, and FETCH in cycle 5.
REQ-042 The bench SHALL apply Op=00, Funct=101000 (immediate) and check EXECUTEI with ALUSrcB=01 and ALUOp=1, then ALUWB with RegW=1; with Funct=001000 it SHALL check EXECUTER with ALUSrcB=00.
REQ-043 The bench SHALL apply Op=10 and check BRANCH in cycle 3 with Branch=1 and ALUSrcA=10, then FETCH; with Op=11 it SHALL check UNKNOWN with all write enables 0, then FETCH.
REQ-044 The bench SHALL drive reset=0 asynchronously during MEMRD and check all outputs go to 0 at once, then FETCH on the first edge after release.
REQ-045 The bench SHALL toggle Op and Funct randomly outside DECODE and MEMADR and check the state sequence is unchanged.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared multicycle-controller definitions.
// State encoding and datapath select codes used by the FSM and datapath.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/main_fsm_outdec.sv
// Moore output table for the main controller.
// Unlisted outputs are 0; everything is 0 while disabled (in reset).
module main_fsm_outdec
    import main_fsm_pkg::*;
(
    input  state_t state,
    input  logic   enable,
    output ctrl_t  ctrl
);

    // Decode the current state into datapath controls
    always_comb begin
        ctrl = '0;
        if (enable) begin
            unique case (state)
                S_FETCH: begin
                    ctrl.ir_write   = 1'b1;
                    ctrl.next_pc    = 1'b1;
                    ctrl.alu_src_a  = SRCA_PC;
                    ctrl.alu_src_b  = SRCB_FOUR;
                    ctrl.result_src = RES_ALURES;
                end
                S_DECODE: begin
                    ctrl.alu_src_a  = SRCA_PC;
                    ctrl.alu_src_b  = SRCB_FOUR;
                    ctrl.result_src = RES_ALURES;
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = SRCA_REG;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    ctrl.adr_src    = 1'b1;
                    ctrl.result_src = RES_ALUOUT;
                end
                S_MEMWB: begin
                    ctrl.result_src = RES_DATA;
                    ctrl.reg_w      = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.adr_src    = 1'b1;
                    ctrl.result_src = RES_ALUOUT;
                    ctrl.mem_w      = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_EXECUTER: begin
                    ctrl.alu_src_a = SRCA_REG;
                    ctrl.alu_src_b = SRCB_WD;
                    ctrl.alu_op    = 1'b1;
                end
                S_EXECUTEI: begin
                    ctrl.alu_src_a = SRCA_REG;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = 1'b1;
                end
                S_ALUWB: begin
                    ctrl.result_src = RES_ALUOUT;
                    ctrl.reg_w      = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a  = SRCA_ALUOUT;
                    ctrl.alu_src_b  = SRCB_IMM;
                    ctrl.result_src = RES_ALURES;
                    ctrl.branch     = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_UNKNOWN: begin
                    ctrl.instr_done = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main controller: state register and next-state logic.
// Op/Funct only steer the machine in DECODE and MEMADR.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       InstrDone
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   unused_funct;

    assign unused_funct = ^Funct[4:1];

    // State register, forced to FETCH while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; illegal encodings recover to FETCH
    always_comb begin
        state_nxt = S_FETCH;
        unique case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                unique case (Op)
                    OP_DP: state_nxt = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM: state_nxt = S_MEMADR;
                    OP_BR: state_nxt = S_BRANCH;
                    OP_UND: state_nxt = S_UNKNOWN;
                    default: state_nxt = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_nxt = S_MEMWB;
            S_EXECUTER: state_nxt = S_ALUWB;
            S_EXECUTEI: state_nxt = S_ALUWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWR:    state_nxt = S_FETCH;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_UNKNOWN:  state_nxt = S_FETCH;
            default:    state_nxt = S_FETCH;
        endcase
    end

    main_fsm_outdec u_outdec (
        .state  (state),
        .enable (reset),
        .ctrl   (ctrl)
    );

    assign IRWrite   = ctrl.ir_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign ALUOp     = ctrl.alu_op;
    assign NextPC    = ctrl.next_pc;
    assign RegW      = ctrl.reg_w;
    assign MemW      = ctrl.mem_w;
    assign Branch    = ctrl.branch;
    assign InstrDone = ctrl.instr_done;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm.
// States are identified by their full output signature.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b01;
    logic [5:0] Funct = 6'b000001;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       InstrDone;
    logic [13:0] outv;

    int checks = 0;
    int failures = 0;

    // {IRW,Adr,A[2],B[2],Res[2],ALUOp,NPC,RegW,MemW,Br,Done}
    localparam logic [13:0] V_ZERO   = 14'b0_0_00_00_00_0_0_0_0_0_0;
    localparam logic [13:0] V_FETCH  = 14'b1_0_01_10_10_0_1_0_0_0_0;
    localparam logic [13:0] V_DECODE = 14'b0_0_01_10_10_0_0_0_0_0_0;
    localparam logic [13:0] V_MEMADR = 14'b0_0_00_01_00_0_0_0_0_0_0;
    localparam logic [13:0] V_MEMRD  = 14'b0_1_00_00_00_0_0_0_0_0_0;
    localparam logic [13:0] V_MEMWB  = 14'b0_0_00_00_01_0_0_1_0_0_1;
    localparam logic [13:0] V_MEMWR  = 14'b0_1_00_00_00_0_0_0_1_0_1;
    localparam logic [13:0] V_EXECR  = 14'b0_0_00_00_00_1_0_0_0_0_0;
    localparam logic [13:0] V_EXECI  = 14'b0_0_00_01_00_1_0_0_0_0_0;
    localparam logic [13:0] V_ALUWB  = 14'b0_0_00_00_00_0_0_1_0_0_1;
    localparam logic [13:0] V_BRANCH = 14'b0_0_10_01_10_0_0_0_0_1_1;
    localparam logic [13:0] V_UNK    = 14'b0_0_00_00_00_0_0_0_0_0_1;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .InstrDone (InstrDone)
    );

    assign outv = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                   ALUOp, NextPC, RegW, MemW, Branch, InstrDone};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [13:0] got,
                       input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk one instruction from FETCH, ending back in FETCH
    task automatic run_instr(input string name, input logic [1:0] op,
                             input logic [5:0] fn, input bit noise);
        logic [13:0] seq [5];
        int n;
        seq = '{default: '0};
        seq[0] = V_FETCH;
        seq[1] = V_DECODE;
        n = 3;
        case (op)
            2'b01: begin
                seq[2] = V_MEMADR;
                if (fn[0]) begin
                    seq[3] = V_MEMRD;
                    seq[4] = V_MEMWB;
                    n = 5;
                end else begin
                    seq[3] = V_MEMWR;
                    n = 4;
                end
            end
            2'b00: begin
                seq[2] = fn[5] ? V_EXECI : V_EXECR;
                seq[3] = V_ALUWB;
                n = 4;
            end
            2'b10: seq[2] = V_BRANCH;
            default: seq[2] = V_UNK;
        endcase
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_c%0d", name, i + 1), outv, seq[i]);
            if (seq[i] == V_DECODE || seq[i] == V_MEMADR || !noise) begin
                Op = op;
                Funct = fn;
            end else begin
                Op = 2'($urandom);
                Funct = 6'($urandom);
            end
            step();
        end
    endtask

    initial begin
        #1;
        chk("rst_initial", outv, V_ZERO);
        step();
        step();
        chk("rst_held", outv, V_ZERO);

        reset = 1'b1;
        #1;
        run_instr("ldr", 2'b01, 6'b000001, 1'b0);
        run_instr("str", 2'b01, 6'b000000, 1'b0);
        run_instr("dpi", 2'b00, 6'b101000, 1'b0);
        run_instr("dpr", 2'b00, 6'b001000, 1'b0);
        run_instr("b", 2'b10, 6'b000000, 1'b0);
        run_instr("und", 2'b11, 6'b000000, 1'b0);

        chk("mid_fetch", outv, V_FETCH);
        Op = 2'b01;
        Funct = 6'b000001;
        step();
        chk("mid_decode", outv, V_DECODE);
        step();
        chk("mid_memadr", outv, V_MEMADR);
        step();
        chk("mid_memrd", outv, V_MEMRD);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async", outv, V_ZERO);
        step();
        chk("rst_async_hold", outv, V_ZERO);
        reset = 1'b1;
        #1;
        run_instr("post_rst", 2'b01, 6'b000001, 1'b0);

        run_instr("nz_ldr", 2'b01, 6'b000001, 1'b1);
        run_instr("nz_str", 2'b01, 6'b111110, 1'b1);
        run_instr("nz_dpi", 2'b00, 6'b100000, 1'b1);
        run_instr("nz_dpr", 2'b00, 6'b011111, 1'b1);
        run_instr("nz_b", 2'b10, 6'b101010, 1'b1);
        run_instr("nz_und", 2'b11, 6'b010101, 1'b1);
        chk("final_fetch", outv, V_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
